// File: rtl/gcd_pkg.sv
// rtl/gcd_pkg.sv - shared types and constants for the GCD job arbiter
//
// Purpose : FSM state type, default operand width and requester-id width
//           shared by the arbiter and its clients.
// Ports   : none (package)
package gcd_pkg;

    localparam int GCD_WIDTH   = 16;
    localparam int GCD_NUM_REQ = 4;
    localparam int ID_W        = $clog2(GCD_NUM_REQ);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_WAIT   = 2'd2,
        ST_RESP   = 2'd3
    } gcd_arb_state_t;

endpackage

// File: rtl/rr_priority_pick.sv
// rtl/rr_priority_pick.sv - combinational round-robin picker
//
// Purpose : returns the first set request bit scanning upward from ptr_i,
//           wrapping at N-1 back to 0.
// Ports   : req_i  [N]   request vector
//           ptr_i  [IW]  index with the highest priority this cycle (< N)
//           gnt_o  [N]   one-hot winner (all zero when nothing requested)
//           idx_o  [IW]  binary index of the winner
//           any_o        at least one request present
module rr_priority_pick #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] idx_o,
    output logic          any_o
);

    always_comb begin
        int pos;
        pos   = 0;
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        for (int i = 0; i < N; i++) begin
            pos = (int'(ptr_i) + i) % N;
            if (!any_o && req_i[pos]) begin
                any_o      = 1'b1;
                gnt_o[pos] = 1'b1;
                idx_o      = IW'(pos);
            end
        end
    end

endmodule

// File: rtl/gcd_job_arbiter.sv
// rtl/gcd_job_arbiter.sv - round-robin sharing of one GCD engine between requesters
//
// Purpose : arbitrates NUM_REQ job requests, captures the winner's operands,
//           runs the shared engine and returns the result tagged with the id.
//           Optional engine watchdog: define GCD_ARB_TIMEOUT_EN.
// Ports   : clk, rst_n            clock, async active-low reset
//           req, a_in, b_in       requester side (level request, packed operands)
//           gnt                   one-hot 1-cycle pulse, operands captured
//           rsp_valid/id/gcd/err  1-cycle result pulse with id, gcd, abort flag
//           eng_start/a/b         engine side, start level + registered operands
//           eng_done/result       engine completion (level) and result
module gcd_job_arbiter
    import gcd_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = GCD_WIDTH,
    parameter int TIMEOUT = 1023
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ*WIDTH-1:0]   a_in,
    input  logic [NUM_REQ*WIDTH-1:0]   b_in,
    output logic [NUM_REQ-1:0]         gnt,
    output logic                       rsp_valid,
    output logic [$clog2(NUM_REQ)-1:0] rsp_id,
    output logic [WIDTH-1:0]           rsp_gcd,
    output logic                       rsp_err,
    output logic                       eng_start,
    output logic [WIDTH-1:0]           eng_a,
    output logic [WIDTH-1:0]           eng_b,
    input  logic                       eng_done,
    input  logic [WIDTH-1:0]           eng_result
);

    localparam int IDW = $clog2(NUM_REQ);

    gcd_arb_state_t     state_q, state_d;
    logic [IDW-1:0]     ptr_q, ptr_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [IDW-1:0]     rsp_id_q, rsp_id_d;
    logic [WIDTH-1:0]   rsp_gcd_q, rsp_gcd_d;
    logic               eng_start_q, eng_start_d;
    logic [WIDTH-1:0]   eng_a_q, eng_a_d;
    logic [WIDTH-1:0]   eng_b_q, eng_b_d;

`ifdef GCD_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] timer_q, timer_d;
    logic          err_q, err_d;
`endif

    logic [NUM_REQ-1:0] pick_onehot;
    logic [IDW-1:0]     pick_idx;
    logic               pick_any;
    logic [WIDTH-1:0]   sel_a, sel_b;

    rr_priority_pick #(
        .N  (NUM_REQ),
        .IW (IDW)
    ) u_pick (
        .req_i (req),
        .ptr_i (ptr_q),
        .gnt_o (pick_onehot),
        .idx_o (pick_idx),
        .any_o (pick_any)
    );

    assign sel_a = a_in[pick_idx*WIDTH +: WIDTH];
    assign sel_b = b_in[pick_idx*WIDTH +: WIDTH];

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        gnt_d       = '0;
        rsp_valid_d = 1'b0;
        rsp_id_d    = rsp_id_q;
        rsp_gcd_d   = rsp_gcd_q;
        eng_start_d = eng_start_q;
        eng_a_d     = eng_a_q;
        eng_b_d     = eng_b_q;
`ifdef GCD_ARB_TIMEOUT_EN
        timer_d     = timer_q;
        err_d       = err_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (pick_any) begin
                    gnt_d    = pick_onehot;
                    rsp_id_d = pick_idx;
                    eng_a_d  = sel_a;
                    eng_b_d  = sel_b;
                    ptr_d    = (pick_idx == IDW'(NUM_REQ - 1)) ? '0 : pick_idx + 1'b1;
`ifdef GCD_ARB_TIMEOUT_EN
                    timer_d  = '0;
                    err_d    = 1'b0;
`endif
                    // Subtractive engine never converges with a zero operand,
                    // so gcd(0,x)=x is answered locally.
                    if (sel_a == '0 || sel_b == '0) begin
                        rsp_gcd_d = sel_a | sel_b;
                        state_d   = ST_RESP;
                    end else begin
                        eng_start_d = 1'b1;
                        state_d     = ST_LAUNCH;
                    end
                end
            end
            // eng_done may still be high from the previous job here; skip it.
            ST_LAUNCH: state_d = ST_WAIT;
            ST_WAIT: begin
                if (eng_done) begin
                    rsp_gcd_d   = eng_result;
                    eng_start_d = 1'b0;
                    state_d     = ST_RESP;
                end
`ifdef GCD_ARB_TIMEOUT_EN
                else if (timer_q == TW'(TIMEOUT - 1)) begin
                    rsp_gcd_d   = '0;
                    eng_start_d = 1'b0;
                    err_d       = 1'b1;
                    state_d     = ST_RESP;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
`endif
            end
            ST_RESP: begin
                rsp_valid_d = 1'b1;
                state_d     = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            ptr_q       <= '0;
            gnt_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_gcd_q   <= '0;
            eng_start_q <= 1'b0;
            eng_a_q     <= '0;
            eng_b_q     <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            gnt_q       <= gnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_gcd_q   <= rsp_gcd_d;
            eng_start_q <= eng_start_d;
            eng_a_q     <= eng_a_d;
            eng_b_q     <= eng_b_d;
        end
    end

`ifdef GCD_ARB_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer_q <= '0;
            err_q   <= 1'b0;
        end else begin
            timer_q <= timer_d;
            err_q   <= err_d;
        end
    end
    assign rsp_err = err_q;
`else
    // Without the watchdog TIMEOUT has no effect and this is constant 0.
    assign rsp_err = (TIMEOUT < 0);
`endif

    assign gnt       = gnt_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_gcd   = rsp_gcd_q;
    assign eng_start = eng_start_q;
    assign eng_a     = eng_a_q;
    assign eng_b     = eng_b_q;

endmodule
